// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and load-use hazard detection.
// Define ID_EX_FWD_EN to enable MEM/WB bypass; otherwise RAW hazards stall instead.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_use_imm,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [4:0]  id_alu_ctrl,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_data,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [4:0]  alu_ctrl,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_store_data,
  output logic        hazard_stall
);

  logic        r_valid;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_use_imm;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd_addr;
  logic [4:0]  r_alu_ctrl;

  logic        w_load_use;
  logic        w_hazard;
  logic        w_clear;
  logic        w_load;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;

  assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd_addr != 5'd0) &
                      ((r_rd_addr == id_rs1_addr) | (r_rd_addr == id_rs2_addr));

`ifdef ID_EX_FWD_EN
  // MEM is the younger producer, so it wins over WB; x0 is never bypassed.
  function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] stored,
                                          input logic mrw, input logic [4:0] mra,
                                          input logic [31:0] md, input logic wrw,
                                          input logic [4:0] wra, input logic [31:0] wd);
    if (mrw && (mra != 5'd0) && (mra == addr)) begin
      return md;
    end else if (wrw && (wra != 5'd0) && (wra == addr)) begin
      return wd;
    end
    return stored;
  endfunction

  assign w_rs1_fwd = fwd_sel(r_rs1_addr, r_rs1_data, mem_reg_write, mem_rd_addr, mem_data,
                             wb_reg_write, wb_rd_addr, wb_data);
  assign w_rs2_fwd = fwd_sel(r_rs2_addr, r_rs2_data, mem_reg_write, mem_rd_addr, mem_data,
                             wb_reg_write, wb_rd_addr, wb_data);
  assign w_hazard  = w_load_use;
`else
  // Without bypass any in-flight producer of a source register must drain first.
  function automatic logic raw_match(input logic [4:0] addr, input logic exv,
                                     input logic exw, input logic [4:0] exa,
                                     input logic mrw, input logic [4:0] mra,
                                     input logic wrw, input logic [4:0] wra);
    return (addr != 5'd0) &&
           ((exv && exw && (exa == addr)) || (mrw && (mra == addr)) || (wrw && (wra == addr)));
  endfunction

  logic w_raw;
  logic w_unused;

  assign w_raw = id_valid &
                 (raw_match(id_rs1_addr, r_valid, r_reg_write, r_rd_addr, mem_reg_write,
                            mem_rd_addr, wb_reg_write, wb_rd_addr) |
                  raw_match(id_rs2_addr, r_valid, r_reg_write, r_rd_addr, mem_reg_write,
                            mem_rd_addr, wb_reg_write, wb_rd_addr));
  assign w_rs1_fwd = r_rs1_data;
  assign w_rs2_fwd = r_rs2_data;
  assign w_hazard  = w_load_use | w_raw;
  assign w_unused  = ^{mem_data, wb_data};
`endif

  // Priority: flush > stall > hazard/idle bubble > normal load.
  assign w_clear = flush | (~stall & (w_hazard | ~id_valid));
  assign w_load  = ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_use_imm   <= 1'b0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_imm       <= 32'd0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_alu_ctrl  <= 5'd0;
    end else if (w_clear) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_use_imm   <= 1'b0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_imm       <= 32'd0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_alu_ctrl  <= 5'd0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_use_imm   <= id_use_imm;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rs1_addr  <= id_rs1_addr;
      r_rs2_addr  <= id_rs2_addr;
      r_rd_addr   <= id_rd_addr;
      r_alu_ctrl  <= id_alu_ctrl;
    end
  end

  assign alu_rs1       = w_rs1_fwd;
  assign alu_rs2       = r_use_imm ? r_imm : w_rs2_fwd;
  assign alu_ctrl      = r_alu_ctrl;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_store_data = w_rs2_fwd;
  // Gated so live MEM/WB inputs cannot raise a stall while reset is held.
  assign hazard_stall  = rst_n & w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares. Expectations track the ID_EX_FWD_EN setting.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush;
  logic        id_valid, id_reg_write, id_mem_read, id_use_imm;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_ctrl;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_data, wb_data;
  logic [31:0] alu_rs1, alu_rs2, ex_store_data;
  logic [4:0]  alu_ctrl, ex_rd_addr;
  logic        ex_valid, ex_reg_write, ex_mem_read, hazard_stall;

  id_ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_use_imm   (id_use_imm),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rd_addr   (id_rd_addr),
    .id_alu_ctrl  (id_alu_ctrl),
    .mem_reg_write(mem_reg_write),
    .mem_rd_addr  (mem_rd_addr),
    .mem_data     (mem_data),
    .wb_reg_write (wb_reg_write),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_ctrl     (alu_ctrl),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd_addr   (ex_rd_addr),
    .ex_store_data(ex_store_data),
    .hazard_stall (hazard_stall)
  );

  typedef struct {
    string       name;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  ctrl;
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [31:0] store;
    logic        hz;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  int     n_cmp = 0;
  int     n_bad = 0;
  logic   fwd_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    end
  endtask

  // Inputs change 1ns after posedge, so each negedge sees the EX state from the
  // previous step plus combinational outputs for the current step's inputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check(x.name, "alu_rs1", alu_rs1, x.rs1);
      check(x.name, "alu_rs2", alu_rs2, x.rs2);
      check(x.name, "alu_ctrl", {27'd0, alu_ctrl}, {27'd0, x.ctrl});
      check(x.name, "ex_valid", {31'd0, ex_valid}, {31'd0, x.v});
      check(x.name, "ex_reg_write", {31'd0, ex_reg_write}, {31'd0, x.rw});
      check(x.name, "ex_mem_read", {31'd0, ex_mem_read}, {31'd0, x.mr});
      check(x.name, "ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, x.rd});
      check(x.name, "ex_store_data", ex_store_data, x.store);
      check(x.name, "hazard_stall", {31'd0, hazard_stall}, {31'd0, x.hz});
    end
  end

  task automatic idle_inputs();
    stall = 0; flush = 0;
    id_valid = 0; id_reg_write = 0; id_mem_read = 0; id_use_imm = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = 0;
    mem_reg_write = 0; mem_rd_addr = 0; mem_data = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic rw, input logic mr, input logic ui,
                        input logic [4:0] rs1a, input logic [31:0] rs1d,
                        input logic [4:0] rs2a, input logic [31:0] rs2d,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] ctrl);
    id_valid = 1; id_reg_write = rw; id_mem_read = mr; id_use_imm = ui;
    id_rs1_addr = rs1a; id_rs1_data = rs1d; id_rs2_addr = rs2a; id_rs2_data = rs2d;
    id_imm = imm; id_rd_addr = rd; id_alu_ctrl = ctrl;
  endtask

  task automatic set_exp(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] ctrl, input logic v, input logic rw, input logic mr,
                         input logic [4:0] rd, input logic [31:0] store, input logic hz);
    e.name = name; e.rs1 = rs1; e.rs2 = rs2; e.ctrl = ctrl; e.v = v; e.rw = rw; e.mr = mr;
    e.rd = rd; e.store = store; e.hz = hz;
  endtask

  task automatic next_step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
`ifdef ID_EX_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    rst_n = 0;
    idle_inputs();

    next_step();
    set_exp("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    // add x3,x1,x2
    next_step(); rst_n = 1;
    set_id(1, 0, 0, 5'd1, 32'd5, 5'd2, 32'd7, 0, 5'd3, 5'd0);
    set_exp("add_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    next_step();
    set_exp("add_result", 5, 7, 0, 1, 1, 0, 3, 7, 0); exp_q.push_back(e);

    next_step();
    set_id(1, 0, 0, 5'd3, 32'h11, 5'd4, 32'h22, 0, 5'd6, 5'd2);
    set_exp("idle_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    // Both MEM and WB target x3; held by stall so bypass is re-evaluated.
    next_step(); stall = 1;
    mem_reg_write = 1; mem_rd_addr = 5'd3; mem_data = 32'h10;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 32'h20;
    set_exp("fwd_mem_prio", fwd_en ? 32'h10 : 32'h11, 32'h22, 2, 1, 1, 0, 6, 32'h22, 0);
    exp_q.push_back(e);

    next_step(); stall = 1;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 32'h20;
    set_exp("fwd_wb_held", fwd_en ? 32'h20 : 32'h11, 32'h22, 2, 1, 1, 0, 6, 32'h22, 0);
    exp_q.push_back(e);

    next_step();
    set_id(1, 0, 0, 5'd0, 32'd0, 5'd7, 32'h33, 0, 5'd8, 5'd3);
    set_exp("stall_release", 32'h11, 32'h22, 2, 1, 1, 0, 6, 32'h22, 0); exp_q.push_back(e);

    next_step();
    mem_reg_write = 1; mem_rd_addr = 5'd0; mem_data = 32'hFFFF_FFFF;
    wb_reg_write = 1; wb_rd_addr = 5'd7; wb_data = 32'h77;
    set_exp("x0_no_fwd", 0, fwd_en ? 32'h77 : 32'h33, 3, 1, 1, 0, 8,
            fwd_en ? 32'h77 : 32'h33, 0);
    exp_q.push_back(e);

    next_step();
    set_id(1, 0, 1, 5'd1, 32'h9, 5'd2, 32'h44, 32'h100, 5'd9, 5'b10001);
    set_exp("bubble2", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    // lw x5, 4(x1)
    next_step();
    set_id(1, 1, 1, 5'd1, 32'h1000, 5'd0, 32'd0, 32'd4, 5'd5, 5'd0);
    set_exp("use_imm", 32'h9, 32'h100, 5'b10001, 1, 1, 0, 9, 32'h44, 0); exp_q.push_back(e);

    // add x6,x1,x5 directly behind the load
    next_step();
    set_id(1, 0, 0, 5'd1, 32'd2, 5'd5, 32'd3, 0, 5'd6, 5'd0);
    set_exp("load_use_hz", 32'h1000, 32'd4, 0, 1, 1, 1, 5, 32'd0, 1); exp_q.push_back(e);

    next_step();
    set_exp("hz_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    next_step();
    set_id(1, 0, 0, 5'd1, 32'hA, 5'd2, 32'hB, 0, 5'd10, 5'd4);
    set_exp("pre_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    next_step(); flush = 1; stall = 1;
    set_id(1, 0, 0, 5'd1, 32'hA, 5'd2, 32'hB, 0, 5'd11, 5'd4);
    set_exp("flush_issue", 32'hA, 32'hB, 4, 1, 1, 0, 10, 32'hB, 0); exp_q.push_back(e);

    next_step();
    set_id(1, 1, 1, 5'd1, 32'hC, 5'd0, 32'd0, 32'd8, 5'd12, 5'd0);
    set_exp("flush_over_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    // Dependent instruction while stalled: stall outranks hazard, EX holds the load.
    next_step(); stall = 1;
    set_id(1, 0, 0, 5'd12, 32'd0, 5'd0, 32'd0, 0, 5'd13, 5'd0);
    set_exp("stall_hold_hz", 32'hC, 32'd8, 0, 1, 1, 1, 12, 32'd0, 1); exp_q.push_back(e);

    next_step(); stall = 1; rst_n = 0;
    set_id(1, 0, 0, 5'd12, 32'd0, 5'd0, 32'd0, 0, 5'd13, 5'd0);
    set_exp("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    next_step(); rst_n = 1;
    set_id(1, 0, 0, 5'd1, 32'h5A, 5'd2, 32'h5B, 0, 5'd14, 5'd1);
    set_exp("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back(e);

    next_step();
    set_exp("post_reset_load", 32'h5A, 32'h5B, 1, 1, 1, 0, 14, 32'h5B, 0); exp_q.push_back(e);

    // Source matches an in-flight MEM write: stall only without bypass.
    next_step();
    set_id(1, 0, 0, 5'd3, 32'h66, 5'd0, 32'd0, 0, 5'd1, 5'd0);
    mem_reg_write = 1; mem_rd_addr = 5'd3; mem_data = 32'h10;
    set_exp("mem_raw", 0, 0, 0, 0, 0, 0, 0, 0, !fwd_en); exp_q.push_back(e);

    next_step();
    if (fwd_en) set_exp("mem_raw_next", 32'h66, 0, 0, 1, 1, 0, 1, 0, 0);
    else        set_exp("mem_raw_next", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(e);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
